upc_loss_monitor: RTL and testbench

- Sequential, parametrised successor to the combinational stolen/discounted LED decoder.
- Accepts one scanned item per valid pulse: UPC code plus secret-mark bit.
- Classifies each item as discounted, stolen or tampered, and keeps saturating per-category counts.
- Drives a held, acknowledge-cleared theft alarm.
- Sits between debounced scan inputs (switches/keys) and the LED/HEX display logic on the DE1 board.

---
 rtl/loss_pkg.sv | 16 +
 rtl/sat_counter.sv | 23 ++
 rtl/upc_loss_monitor.sv | 130 +++++++++++++
 tb/tb_upc_loss_monitor.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/loss_pkg.sv
// Shared types and default item masks for the UPC loss monitor.
// Bit i of each mask describes UPC code i.
package loss_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_ACK = 2'd2
    } alarm_state_t;

    // 000 shoes, 001 jewelry, 011 bike, 100 suit, 101 coat, 110 socks; 010/111 unused
    localparam logic [7:0] DEF_VALID_MASK = 8'h7B;
    localparam logic [7:0] DEF_DISC_MASK  = 8'h68;
    localparam logic [7:0] DEF_EXP_MASK   = 8'h31;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// clear has priority over inc.
module sat_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/upc_loss_monitor.sv
// Classifies scanned items, keeps saturating event counts and drives the
// held, acknowledge-cleared theft alarm.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no theft pending, alarm low
// HOLD     | alarm high, hold_cnt timing down, ack ignored
// WAIT_ACK | alarm high, hold time served, waiting for operator ack
module upc_loss_monitor
    import loss_pkg::*;
#(
    parameter int unsigned         UPC_W      = 3,
    parameter int unsigned         CNT_W      = 4,
    parameter int unsigned         HOLD_CYC   = 8,
    parameter logic [2**UPC_W-1:0] VALID_MASK = DEF_VALID_MASK,
    parameter logic [2**UPC_W-1:0] DISC_MASK  = DEF_DISC_MASK,
    parameter logic [2**UPC_W-1:0] EXP_MASK   = DEF_EXP_MASK
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             scan_valid,
    input  logic [UPC_W-1:0] upc,
    input  logic             mark,
    input  logic             ack,
    input  logic             clear,
    output logic             discounted,
    output logic             stolen,
    output logic             tamper,
    output logic             invalid,
    output logic             alarm,
    output logic [CNT_W-1:0] stolen_cnt,
    output logic [CNT_W-1:0] disc_cnt,
    output logic [CNT_W-1:0] total_cnt
);

    localparam int unsigned      HOLD_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);

    logic valid_c, disc_c, stolen_c, tamper_c;
    logic scan_take, stolen_ev;

    alarm_state_t      state, state_nx;
    logic [HOLD_W-1:0] hold_cnt, hold_nx;

    assign valid_c  = VALID_MASK[upc];
    assign disc_c   = valid_c & DISC_MASK[upc];
    assign stolen_c = valid_c & EXP_MASK[upc] & ~mark;
    assign tamper_c = valid_c & ~EXP_MASK[upc] & mark;

    // A scan coincident with clear is dropped entirely, including for the FSM
    assign scan_take = scan_valid & ~clear;
    assign stolen_ev = scan_take & stolen_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {discounted, stolen, tamper, invalid} <= 4'b0000;
        end else if (clear) begin
            {discounted, stolen, tamper, invalid} <= 4'b0000;
        end else if (scan_valid) begin
            discounted <= disc_c;
            stolen     <= stolen_c;
            tamper     <= tamper_c;
            invalid    <= ~valid_c;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stolen_cnt (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .inc(stolen_ev), .count(stolen_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_disc_cnt (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .inc(scan_take & disc_c), .count(disc_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_total_cnt (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .inc(scan_take & valid_c), .count(total_cnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            alarm    <= 1'b0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_nx;
            alarm    <= (state_nx != IDLE);
        end
    end

    // WAIT_ACK is entered on the edge where hold_cnt reaches 0, giving HOLD_CYC alarm cycles
    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        case (state)
            IDLE: begin
                if (stolen_ev) begin
                    state_nx = HOLD;
                    hold_nx  = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (stolen_ev) begin
                    hold_nx = HOLD_LOAD;
                end else if (hold_cnt <= HOLD_W'(1)) begin
                    state_nx = WAIT_ACK;
                    hold_nx  = '0;
                end else begin
                    hold_nx = hold_cnt - HOLD_W'(1);
                end
            end
            WAIT_ACK: begin
                if (stolen_ev) begin
                    state_nx = HOLD;
                    hold_nx  = HOLD_LOAD;
                end else if (ack) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                hold_nx  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_upc_loss_monitor.sv
// Directed bench for upc_loss_monitor: a classification table plus
// hand-written alarm, saturation, clear and async-reset sequences.
module tb_upc_loss_monitor;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       scan_valid;
    logic [2:0] upc;
    logic       mark;
    logic       ack;
    logic       clear;
    logic       discounted, stolen, tamper, invalid, alarm;
    logic [3:0] stolen_cnt, disc_cnt, total_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [2:0] upc;
        logic       mark;
        logic       disc;
        logic       stol;
        logic       tamp;
        logic       inv;
    } vec_t;

    vec_t vecs [16];

    always #5 clk = ~clk;

    upc_loss_monitor dut (
        .clk(clk), .reset_n(reset_n), .scan_valid(scan_valid), .upc(upc),
        .mark(mark), .ack(ack), .clear(clear), .discounted(discounted),
        .stolen(stolen), .tamper(tamper), .invalid(invalid), .alarm(alarm),
        .stolen_cnt(stolen_cnt), .disc_cnt(disc_cnt), .total_cnt(total_cnt)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        scan_valid = 1'b0; upc = 3'd0; mark = 1'b0; ack = 1'b0; clear = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic drive_scan(input logic [2:0] u, input logic m);
        scan_valid = 1'b1;
        upc = u;
        mark = m;
    endtask

    initial begin
        int es, ed, et;

        // upc, mark -> discounted, stolen, tamper, invalid
        vecs[0]  = '{3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{3'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{3'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        reset_n = 1'b0;
        scan_valid = 1'b0; upc = 3'd0; mark = 1'b0; ack = 1'b0; clear = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_alarm", {7'd0, alarm}, 8'd0);
        chk("rst_class", {4'd0, discounted, stolen, tamper, invalid}, 8'd0);
        chk("rst_stolen_cnt", {4'd0, stolen_cnt}, 8'd0);
        chk("rst_total_cnt", {4'd0, total_cnt}, 8'd0);
        reset_n = 1'b1;

        // classification table with running count expectations
        es = 0; ed = 0; et = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive_scan(vecs[i].upc, vecs[i].mark);
            @(negedge clk);
            scan_valid = 1'b0;
            if (vecs[i].stol) es++;
            if (vecs[i].disc) ed++;
            if (!vecs[i].inv) et++;
            chk($sformatf("vec%0d_disc", i), {7'd0, discounted}, {7'd0, vecs[i].disc});
            chk($sformatf("vec%0d_stolen", i), {7'd0, stolen}, {7'd0, vecs[i].stol});
            chk($sformatf("vec%0d_tamper", i), {7'd0, tamper}, {7'd0, vecs[i].tamp});
            chk($sformatf("vec%0d_invalid", i), {7'd0, invalid}, {7'd0, vecs[i].inv});
            chk($sformatf("vec%0d_stolen_cnt", i), {4'd0, stolen_cnt}, 8'(es > 15 ? 15 : es));
            chk($sformatf("vec%0d_disc_cnt", i), {4'd0, disc_cnt}, 8'(ed > 15 ? 15 : ed));
            chk($sformatf("vec%0d_total_cnt", i), {4'd0, total_cnt}, 8'(et > 15 ? 15 : et));
        end

        // first stolen scan after reset: alarm and counts on the next cycle
        do_reset();
        drive_scan(3'd0, 1'b0);
        @(negedge clk);
        scan_valid = 1'b0;
        chk("first_stolen", {7'd0, stolen}, 8'd1);
        chk("first_alarm", {7'd0, alarm}, 8'd1);
        chk("first_stolen_cnt", {4'd0, stolen_cnt}, 8'd1);
        chk("first_total_cnt", {4'd0, total_cnt}, 8'd1);
        chk("first_disc", {7'd0, discounted}, 8'd0);

        // tamper alone never raises the alarm; outputs hold without scans
        do_reset();
        drive_scan(3'd1, 1'b1);
        @(negedge clk);
        scan_valid = 1'b0;
        chk("tamper_set", {7'd0, tamper}, 8'd1);
        chk("tamper_no_alarm", {7'd0, alarm}, 8'd0);
        repeat (3) @(negedge clk);
        chk("tamper_held", {7'd0, tamper}, 8'd1);

        // steady ack: alarm high exactly 8 cycles
        do_reset();
        ack = 1'b1;
        drive_scan(3'd0, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            scan_valid = 1'b0;
            chk($sformatf("hold8_k%0d", k), {7'd0, alarm}, {7'd0, (k <= 8)});
        end

        // re-scan at cycle 5 extends the alarm to 5+8
        do_reset();
        ack = 1'b1;
        drive_scan(3'd0, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk($sformatf("extend_k%0d", k), {7'd0, alarm}, {7'd0, (k <= 13)});
            scan_valid = (k == 5);
        end
        scan_valid = 1'b0;

        // stolen and ack together in WAIT_ACK: stolen wins, HOLD restarts
        do_reset();
        drive_scan(3'd0, 1'b0);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            chk($sformatf("waitack_k%0d", k), {7'd0, alarm}, {7'd0, (k <= 16)});
            scan_valid = (k == 8);
            ack = (k >= 8);
        end
        scan_valid = 1'b0;
        ack = 1'b0;

        // saturation at 15
        do_reset();
        drive_scan(3'd3, 1'b0);
        repeat (20) @(negedge clk);
        scan_valid = 1'b0;
        chk("sat_disc_cnt", {4'd0, disc_cnt}, 8'd15);
        chk("sat_total_cnt", {4'd0, total_cnt}, 8'd15);
        chk("sat_stolen_cnt", {4'd0, stolen_cnt}, 8'd0);
        chk("sat_disc", {7'd0, discounted}, 8'd1);

        // clear wins over a coincident stolen scan
        clear = 1'b1;
        drive_scan(3'd0, 1'b0);
        @(negedge clk);
        clear = 1'b0;
        scan_valid = 1'b0;
        chk("clr_disc_cnt", {4'd0, disc_cnt}, 8'd0);
        chk("clr_total_cnt", {4'd0, total_cnt}, 8'd0);
        chk("clr_stolen_cnt", {4'd0, stolen_cnt}, 8'd0);
        chk("clr_class", {4'd0, discounted, stolen, tamper, invalid}, 8'd0);
        chk("clr_no_alarm", {7'd0, alarm}, 8'd0);

        // clear leaves a running alarm alone
        drive_scan(3'd4, 1'b0);
        @(negedge clk);
        scan_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_keeps_alarm", {7'd0, alarm}, 8'd1);
        chk("clr_stolen_out", {7'd0, stolen}, 8'd0);
        chk("clr_stolen_cnt2", {4'd0, stolen_cnt}, 8'd0);

        // asynchronous reset between edges during HOLD
        do_reset();
        drive_scan(3'd0, 1'b0);
        @(negedge clk);
        scan_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_areset_alarm", {7'd0, alarm}, 8'd1);
        chk("pre_areset_cnt", {4'd0, stolen_cnt}, 8'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_alarm", {7'd0, alarm}, 8'd0);
        chk("areset_stolen_cnt", {4'd0, stolen_cnt}, 8'd0);
        chk("areset_total_cnt", {4'd0, total_cnt}, 8'd0);
        chk("areset_stolen", {7'd0, stolen}, 8'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_areset_idle", {7'd0, alarm}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
